// File: rtl/vram_draw_pkg.sv
// Shared types for the VRAM stroke writer.
//   state_t  : top-level write-port owner states (clear fill, idle, line drawing)
//   point_t  : pixel coordinate pair; touch coordinates are zero-extended into it
//   in_range : true when a point lies inside a w x h display
package vram_draw_pkg;

  // Coordinate field width. Touch inputs (XW/YW bits) must not be wider than this.
  localparam int COORD_W = 9;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_LINE
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  function automatic logic in_range(input point_t p, input int w, input int h);
    return (int'(p.x) < w) && (int'(p.y) < h);
  endfunction

endpackage

// File: rtl/bresenham_stepper.sv
// Bresenham line stepper, one point per step.
//   clk, rst : clock, synchronous active-high reset
//   start_i  : load a new segment p0_i -> p1_i; cur_o becomes p0_i
//   p0_i     : segment start point
//   p1_i     : segment end point
//   step_i   : advance cur_o by one pixel (ignored once the end is reached)
//   cur_o    : current point of the segment
//   last_o   : cur_o equals the segment end point
module bresenham_stepper
  import vram_draw_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start_i,
  input  point_t p0_i,
  input  point_t p1_i,
  input  logic   step_i,
  output point_t cur_o,
  output logic   last_o
);

  // Two extra bits: one for sign, one so err = dx + dy never overflows.
  localparam int EW = COORD_W + 2;

  point_t                cur_q, cur_d;
  point_t                end_q;
  logic signed [EW-1:0]  dx_q, dy_q, err_q, err_d;
  logic                  sx_neg_q, sy_neg_q;

  logic signed [EW-1:0]  x0_s, y0_s, x1_s, y1_s, ddx, ddy, adx, ady;
  logic signed [EW:0]    e2, dx_ext, dy_ext;
  logic                  move_x, move_y;

  assign x0_s = $signed({2'b00, p0_i.x});
  assign y0_s = $signed({2'b00, p0_i.y});
  assign x1_s = $signed({2'b00, p1_i.x});
  assign y1_s = $signed({2'b00, p1_i.y});
  assign ddx  = x1_s - x0_s;
  assign ddy  = y1_s - y0_s;
  assign adx  = ddx[EW-1] ? -ddx : ddx;
  assign ady  = ddy[EW-1] ? -ddy : ddy;

  // e2 = 2*err, compared against sign-extended dx/dy one bit wider.
  assign e2     = {err_q, 1'b0};
  assign dx_ext = dx_q;
  assign dy_ext = dy_q;
  assign move_x = (e2 >= dy_ext);
  assign move_y = (e2 <= dx_ext);

  assign cur_o  = cur_q;
  assign last_o = (cur_q == end_q);

  always_comb begin
    cur_d = cur_q;
    err_d = err_q;
    if (step_i && !last_o) begin
      // Both corrections use the error from before this step.
      err_d = err_q + (move_x ? dy_q : '0) + (move_y ? dx_q : '0);
      if (move_x) cur_d.x = sx_neg_q ? cur_q.x - 1'b1 : cur_q.x + 1'b1;
      if (move_y) cur_d.y = sy_neg_q ? cur_q.y - 1'b1 : cur_q.y + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q    <= '0;
      end_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else if (start_i) begin
      cur_q    <= p0_i;
      end_q    <= p1_i;
      dx_q     <= adx;
      dy_q     <= -ady;
      err_q    <= adx - ady;
      sx_neg_q <= ddx[EW-1];
      sy_neg_q <= ddy[EW-1];
    end else begin
      cur_q <= cur_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/vram_stroke_writer.sv
// Owns the VRAM write port: background fill after reset/clear, then converts
// touch samples into pen-coloured pixels, joining consecutive pen-down samples
// with Bresenham segments drawn at one pixel per clock.
//   clk, rst      : clock, synchronous active-high reset
//   touch_valid   : touch sample present this cycle (level)
//   touch_x/_y    : touch column / row
//   clear         : one-cycle request to restart the full background fill
//   bg_color      : fill colour, pen_color : stroke colour
//   wr_ena        : VRAM write strobe
//   wr_addr       : VRAM address = y*DISPLAY_WIDTH + x
//   wr_data       : VRAM write data
//   busy          : high while filling or drawing a line
module vram_stroke_writer
  import vram_draw_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int VRAM_W         = 16,
  parameter int XW             = 9,
  parameter int YW             = 9,
  // Derived; leave at defaults.
  parameter int VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int AW             = $clog2(VRAM_L)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              touch_valid,
  input  logic [XW-1:0]     touch_x,
  input  logic [YW-1:0]     touch_y,
  input  logic              clear,
  input  logic [VRAM_W-1:0] bg_color,
  input  logic [VRAM_W-1:0] pen_color,
  output logic              wr_ena,
  output logic [AW-1:0]     wr_addr,
  output logic [VRAM_W-1:0] wr_data,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [AW-1:0]       count_q, count_d;
  logic                pen_down_q, pen_down_d;
  point_t              last_q, last_d;
  logic                pend_valid_q, pend_valid_d;
  point_t              pend_q, pend_d;

  logic                wr_ena_q, wr_ena_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [VRAM_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q;

  point_t              live_pt, sample;
  logic                have_sample;
  logic                step_start, step_adv, step_last;
  point_t              step_cur;

  function automatic logic [AW-1:0] addr_of(input point_t p);
    return AW'(p.y) * AW'(DISPLAY_WIDTH) + AW'(p.x);
  endfunction

  bresenham_stepper u_stepper (
    .clk     (clk),
    .rst     (rst),
    .start_i (step_start),
    .p0_i    (last_q),
    .p1_i    (sample),
    .step_i  (step_adv),
    .cur_o   (step_cur),
    .last_o  (step_last)
  );

  always_comb begin
    live_pt.x = COORD_W'(touch_x);
    live_pt.y = COORD_W'(touch_y);
  end

  // A buffered sample (captured during a line) is served before the live one.
  assign sample      = pend_valid_q ? pend_q : live_pt;
  assign have_sample = pend_valid_q || touch_valid;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    pen_down_d   = pen_down_q;
    last_d       = last_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    wr_ena_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    step_start   = 1'b0;
    step_adv     = 1'b0;

    case (state_q)
      S_CLEAR: begin
        wr_ena_d  = 1'b1;
        wr_addr_d = count_q;
        wr_data_d = bg_color;
        if (count_q == '0) state_d = S_IDLE;
        else               count_d = count_q - 1'b1;
      end

      S_IDLE: begin
        if (have_sample) begin
          pend_valid_d = 1'b0;
          if (!in_range(sample, DISPLAY_WIDTH, DISPLAY_HEIGHT)) begin
            pen_down_d = 1'b0;
          end else if (!pen_down_q) begin
            wr_ena_d   = 1'b1;
            wr_addr_d  = addr_of(sample);
            wr_data_d  = pen_color;
            last_d     = sample;
            pen_down_d = 1'b1;
          end else if (sample != last_q) begin
            step_start = 1'b1;
            state_d    = S_LINE;
          end
        end
      end

      S_LINE: begin
        wr_ena_d  = 1'b1;
        wr_addr_d = addr_of(step_cur);
        wr_data_d = pen_color;
        step_adv  = 1'b1;
        if (step_last) begin
          last_d  = step_cur;
          state_d = S_IDLE;
        end
        // Last sample wins; it becomes the next segment end.
        if (touch_valid && in_range(live_pt, DISPLAY_WIDTH, DISPLAY_HEIGHT)) begin
          pend_d       = live_pt;
          pend_valid_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Lifting the pen never aborts a line already in progress.
    if (state_q != S_CLEAR && !touch_valid) pen_down_d = 1'b0;

    // The write computed this cycle still goes out; only the next state changes.
    if (clear) begin
      state_d      = S_CLEAR;
      count_d      = AW'(VRAM_L - 1);
      pend_valid_d = 1'b0;
      pen_down_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      count_q      <= AW'(VRAM_L - 1);
      pen_down_q   <= 1'b0;
      last_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      wr_ena_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      pen_down_q   <= pen_down_d;
      last_q       <= last_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      wr_ena_q     <= wr_ena_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      // Aligned with the write registered alongside it.
      busy_q       <= (state_q != S_IDLE);
    end
  end

  assign wr_ena  = wr_ena_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule
